// File: rtl/reaction_timer_multi.sv
`default_nettype none
// ============================================================================
//  Module   : reaction_timer_multi
//  Purpose  : Multi-channel reaction timer. A common start arms every
//             channel; each channel counts tick strobes until its own
//             respond input fires (DONE) or MAX_COUNT is reached (TOUT).
//             Results are held until the next start or clear.
//  Optional : RTIMER_BEST_EN - when defined, a best-time tracker reports
//             the fastest DONE channel one cycle after busy falls. When
//             undefined the best_* ports are tied to their idle values.
//  Ports    : clock, rst_n (async, active-low)
//             tick, start, clear         - common controls
//             respond[CHANNELS]          - per-channel stop, level-sampled
//             count_time[CHANNELS*WIDTH] - channel i at [i*WIDTH +: WIDTH]
//             done, timeout [CHANNELS]   - per-channel stop reason
//             busy                       - any channel in RUN
//             best_time, best_chan, best_valid - fastest DONE result
//  Revision : 1.0 - initial release
// ============================================================================
module reaction_timer_multi #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 14,
    parameter int MAX_COUNT = 9999,
    parameter int CW        = (CHANNELS == 1) ? 1 : $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic                      start,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       respond,
    output logic [CHANNELS*WIDTH-1:0] count_time,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       timeout,
    output logic                      busy,
    output logic [WIDTH-1:0]          best_time,
    output logic [CW-1:0]             best_chan,
    output logic                      best_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        TOUT = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_max_cnt = WIDTH'(MAX_COUNT);

    state_t           state_q [CHANNELS];
    state_t           state_d [CHANNELS];
    logic [WIDTH-1:0] cnt_q   [CHANNELS];
    logic [WIDTH-1:0] cnt_d   [CHANNELS];
    logic             busy_next;

    // Per-channel next state. Priority: clear > start > respond > tick.
    always_comb begin
        busy_next = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (clear) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else if (start) begin
                state_d[i] = RUN;
                cnt_d[i]   = '0;
            end else if (state_q[i] == RUN) begin
                if (respond[i]) begin
                    state_d[i] = DONE;
                end else if (tick) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                    // Stopping exactly on the limit means no wrap is possible.
                    if (cnt_q[i] + 1'b1 == c_max_cnt) begin
                        state_d[i] = TOUT;
                    end
                end
            end
            if (state_d[i] == RUN) begin
                busy_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Outputs are pure decodes of the registered state.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign count_time[g*WIDTH +: WIDTH] = cnt_q[g];
        assign done[g]    = (state_q[g] == DONE);
        assign timeout[g] = (state_q[g] == TOUT);
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (state_q[i] == RUN) begin
                busy = 1'b1;
            end
        end
    end

`ifdef RTIMER_BEST_EN
    logic             fall_pend_q, fall_pend_d;
    logic [WIDTH-1:0] best_time_q, best_time_d;
    logic [CW-1:0]    best_chan_q, best_chan_d;
    logic             best_valid_q, best_valid_d;
    logic [WIDTH-1:0] min_time;
    logic [CW-1:0]    min_chan;
    logic             any_done;

    always_comb begin
        min_time = '1;
        min_chan = '0;
        any_done = 1'b0;
        // Strict less-than keeps the lowest index on ties.
        for (int i = 0; i < CHANNELS; i++) begin
            if (state_q[i] == DONE && (!any_done || cnt_q[i] < min_time)) begin
                min_time = cnt_q[i];
                min_chan = CW'(i);
                any_done = 1'b1;
            end
        end

        // A natural end of run (last channel leaving RUN without clear/start)
        // is flagged here and evaluated one cycle later, once the stop
        // results have settled into the count registers.
        fall_pend_d  = busy && !busy_next && !clear && !start;
        best_time_d  = best_time_q;
        best_chan_d  = best_chan_q;
        best_valid_d = best_valid_q;
        if (clear || start) begin
            best_valid_d = 1'b0;
        end else if (fall_pend_q) begin
            best_time_d  = any_done ? min_time : '1;
            best_chan_d  = min_chan;
            best_valid_d = any_done;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            fall_pend_q  <= 1'b0;
            best_time_q  <= '1;
            best_chan_q  <= '0;
            best_valid_q <= 1'b0;
        end else begin
            fall_pend_q  <= fall_pend_d;
            best_time_q  <= best_time_d;
            best_chan_q  <= best_chan_d;
            best_valid_q <= best_valid_d;
        end
    end

    assign best_time  = best_time_q;
    assign best_chan  = best_chan_q;
    assign best_valid = best_valid_q;
`else
    assign best_time  = '1;
    assign best_chan  = '0;
    assign best_valid = 1'b0;
`endif

endmodule
`default_nettype wire
